instr_prefetch_buffer: RTL and testbench

- Fetch stage placed directly upstream of the single-cycle MIPS core.
- Fetches 32-bit instruction words from an external instruction memory over a req/ack handshake. Queues up to DEPTH words with their PCs in a FIFO and presents them to the core as a valid/ready stream.
- On a core redirect (taken branch or jump), flushes all queued words and restarts fetching at the redirect target.

---
 rtl/instr_prefetch_buffer.sv | 249 ++++++++++++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_prefetch_buffer
//
// Fetch stage sitting in front of the single-cycle MIPS core. It fetches 32-bit
// instruction words from instruction memory over a req/ack handshake, queues
// up to DEPTH {pc, word} pairs in a FIFO and presents the head entry to the
// core as a valid/ready stream. A core redirect flushes the queue and restarts
// fetching at the redirect target.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous, active-low reset
//   mem_req      fetch request, held until mem_ack
//   mem_addr     word address of the pending request
//   mem_ack      memory accepts the request and returns mem_rdata this cycle
//   mem_rdata    instruction word returned with mem_ack
//   inst_valid   head of the FIFO holds an instruction
//   inst         head instruction word (0 when empty)
//   inst_pc      PC of the head instruction (0 when empty)
//   inst_ready   core consumes the head this cycle
//   redirect     flush the queue and restart fetching
//   redirect_pc  new fetch PC, bits [1:0] ignored
//
// Optional feature (macro PREFETCH_STATS_EN):
//   stat_fetched    saturating count of words pushed into the FIFO
//   stat_discarded  saturating count of acked words dropped plus entries
//                   flushed by redirects
// -----------------------------------------------------------------------------
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_discarded
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  entry_t             fifo_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic               push;
  logic               pop;
  logic               ack_dropped;
  logic [CNT_W-1:0]   count_next;
  logic               room_next;
  logic [31:0]        redirect_target;
  logic [31:0]        fetch_pc_inc;
  logic               unused_redirect_lsbs;

  // ---------------------------------------------------------------------------
  // Next-cycle bookkeeping. Redirect wins over both push and pop: the acked
  // word of a redirect-coincident ack is dropped and the pop is ignored.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    push            = 1'b0;
    pop             = 1'b0;
    ack_dropped     = 1'b0;
    count_next      = count;
    redirect_target = {redirect_pc[31:2], 2'b00};
    fetch_pc_inc    = fetch_pc + 32'd4;

    push        = (state == REQ) && mem_ack && !redirect;
    pop         = inst_ready && (count != '0) && !redirect;
    ack_dropped = mem_ack && ((state == DISCARD) || ((state == REQ) && redirect));

    if (redirect) begin
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign room_next            = (count_next < DEPTH_C);
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // Output path: head entry read combinationally, forced to zero when empty so
  // the core never sees stale words after reset or a flush.
  // ---------------------------------------------------------------------------
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? fifo_q[rd_ptr].word : 32'h0;
  assign inst_pc    = inst_valid ? fifo_q[rd_ptr].pc   : 32'h0;

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; its contents only become visible
  // through inst/inst_pc once count says the entry was written, so resetting
  // it would buy nothing but reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= '{pc: fetch_pc, word: mem_rdata};
    end
  end

  // Pointers wrap modulo DEPTH; the explicit count removes full/empty
  // ambiguity when they are equal.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM. mem_req and mem_addr are registered. In REQ mem_addr tracks
  // fetch_pc; in DISCARD it keeps the address of the abandoned request so the
  // handshake stays stable while fetch_pc already holds the new target.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_target;
            mem_addr <= redirect_target;
            mem_req  <= 1'b1;
            state    <= REQ;
          end else if (room_next) begin
            mem_addr <= fetch_pc;
            mem_req  <= 1'b1;
            state    <= REQ;
          end
        end

        REQ: begin
          if (redirect) begin
            fetch_pc <= redirect_target;
            if (mem_ack) begin
              // Acked word dropped; the next request goes straight out.
              mem_addr <= redirect_target;
            end else begin
              // Request still outstanding: wait out its ack.
              state <= DISCARD;
            end
          end else if (mem_ack) begin
            fetch_pc <= fetch_pc_inc;
            mem_addr <= fetch_pc_inc;
            if (!room_next) begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end

        DISCARD: begin
          if (redirect) begin
            fetch_pc <= redirect_target;
          end
          if (mem_ack) begin
            mem_addr <= redirect ? redirect_target : fetch_pc;
            state    <= REQ;
          end
        end

        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef PREFETCH_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters.
  // ---------------------------------------------------------------------------
  logic [32:0] fetched_sum;
  logic [32:0] discarded_sum;

  always_comb begin
    fetched_sum   = {1'b0, stat_fetched} + 33'(push);
    discarded_sum = {1'b0, stat_discarded} + 33'(ack_dropped);
    if (redirect) begin
      discarded_sum = discarded_sum + 33'(count);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched   <= '0;
      stat_discarded <= '0;
    end else begin
      stat_fetched   <= fetched_sum[32]   ? 32'hFFFF_FFFF : fetched_sum[31:0];
      stat_discarded <= discarded_sum[32] ? 32'hFFFF_FFFF : discarded_sum[31:0];
    end
  end
`else
  logic unused_ack_dropped;
  assign unused_ack_dropped = ack_dropped;
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for instr_prefetch_buffer (DEPTH=4, RESET_PC=0).
// Instruction memory is modelled as a pure function of the address; every
// expected value below is derived from that function and hand-traced timing.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_buffer;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_discarded;
`endif

  int checks   = 0;
  int failures = 0;

  instr_prefetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_discarded (stat_discarded)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
  endfunction

  // Memory model: data is meaningful only alongside mem_ack.
  assign mem_rdata = mem_ack ? word_of(mem_addr) : 32'hBAD0_BAD0;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset over two edges, release it between edges.
  task automatic do_reset();
    rst         = 1'b0;
    mem_ack     = 1'b0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_req, mem_addr} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset_req got req=%0b addr=%h expected req=0 addr=0", mem_req, mem_addr);
    end
    checks++;
    if ({inst_valid, inst, inst_pc} !== {1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_head got valid=%0b inst=%h pc=%h expected 0/0/0", inst_valid, inst, inst_pc);
    end
`ifdef PREFETCH_STATS_EN
    checks++;
    if ({stat_fetched, stat_discarded} !== 64'h0) begin
      failures++;
      $display("FAIL reset_stats got fetched=%0d discarded=%0d expected 0/0", stat_fetched, stat_discarded);
    end
`endif
  endtask

  // Immediate acks, core always ready: one word per cycle.
  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    mem_ack    = 1'b1;
    inst_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 32'(4 * (k - 1))}) begin
        failures++;
        $display("FAIL stream_addr cycle=%0d got req=%0b addr=%h expected req=1 addr=%h",
                 k, mem_req, mem_addr, 32'(4 * (k - 1)));
      end
      if (k == 1) begin
        checks++;
        if (inst_valid !== 1'b0) begin
          failures++;
          $display("FAIL stream_first_empty got valid=%0b expected 0", inst_valid);
        end
      end else begin
        exp_pc = 32'(4 * (k - 2));
        checks++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, exp_pc, word_of(exp_pc)}) begin
          failures++;
          $display("FAIL stream_head cycle=%0d got valid=%0b pc=%h inst=%h expected 1/%h/%h",
                   k, inst_valid, inst_pc, inst, exp_pc, word_of(exp_pc));
        end
      end
    end
  endtask

  // Core stalled: FIFO fills to 4, mem_req drops; one pop buys one request.
  // Then a redirect from IDLE delivers the target word two edges later.
  task automatic test_backpressure();
    int pushes;
    do_reset();
    mem_ack    = 1'b1;
    inst_ready = 1'b0;
    pushes     = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req && mem_ack) pushes++;
      tick();
    end
    checks++;
    if (pushes !== 4) begin
      failures++;
      $display("FAIL bp_fill_pushes got %0d expected 4", pushes);
    end
    checks++;
    if ({mem_req, inst_valid, inst_pc} !== {1'b0, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL bp_full_state got req=%0b valid=%0b pc=%h expected 0/1/0", mem_req, inst_valid, inst_pc);
    end
`ifdef PREFETCH_STATS_EN
    checks++;
    if (stat_fetched !== 32'd4) begin
      failures++;
      $display("FAIL bp_stat_fetched got %0d expected 4", stat_fetched);
    end
`endif
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++;
    if ({mem_req, mem_addr, inst_pc} !== {1'b1, 32'h10, 32'h4}) begin
      failures++;
      $display("FAIL bp_one_pop got req=%0b addr=%h pc=%h expected 1/10/4", mem_req, mem_addr, inst_pc);
    end
    pushes = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req && mem_ack) pushes++;
      tick();
    end
    checks++;
    if ({pushes, mem_req} !== {32'd1, 1'b0}) begin
      failures++;
      $display("FAIL bp_refill got pushes=%0d req=%0b expected 1/0", pushes, mem_req);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    checks++;
    if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h40}) begin
      failures++;
      $display("FAIL bp_idle_redirect got valid=%0b req=%0b addr=%h expected 0/1/40",
               inst_valid, mem_req, mem_addr);
    end
    tick();
    checks++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h40, word_of(32'h40)}) begin
      failures++;
      $display("FAIL bp_redirect_word got valid=%0b pc=%h inst=%h expected 1/40/%h",
               inst_valid, inst_pc, inst, word_of(32'h40));
    end
    mem_ack = 1'b0;
  endtask

  // Ack arrives three cycles late; the request must hold steady.
  task automatic test_ack_delay();
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_req, mem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
        failures++;
        $display("FAIL delay_hold wait=%0d got req=%0b addr=%h valid=%0b expected 1/0/0",
                 i, mem_req, mem_addr, inst_valid);
      end
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({inst_valid, inst_pc, inst, mem_addr} !== {1'b1, 32'h0, word_of(32'h0), 32'h4}) begin
      failures++;
      $display("FAIL delay_push got valid=%0b pc=%h inst=%h addr=%h expected 1/0/%h/4",
               inst_valid, inst_pc, inst, mem_addr, word_of(32'h0));
    end
  endtask

  // Redirect to 0x100 while the request to 0x8 is waiting.
  task automatic test_redirect_discard();
    do_reset();
    mem_ack = 1'b1;
    tick();
    tick();
    tick();
    mem_ack = 1'b0;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h8}) begin
        failures++;
        $display("FAIL discard_hold cycle=%0d got valid=%0b req=%0b addr=%h expected 0/1/8",
                 i, inst_valid, mem_req, mem_addr);
      end
      if (i < 2) tick();
    end
    mem_ack = 1'b1;
    tick();
    checks++;
    if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h100}) begin
      failures++;
      $display("FAIL discard_drop got valid=%0b req=%0b addr=%h expected 0/1/100",
               inst_valid, mem_req, mem_addr);
    end
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h100, word_of(32'h100)}) begin
      failures++;
      $display("FAIL discard_next got valid=%0b pc=%h inst=%h expected 1/100/%h",
               inst_valid, inst_pc, inst, word_of(32'h100));
    end
  endtask

  // Redirect together with inst_ready, three entries queued, unaligned target.
  task automatic test_redirect_ready();
    do_reset();
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    mem_ack     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    inst_ready  = 1'b1;
    tick();
    redirect   = 1'b0;
    inst_ready = 1'b0;
    checks++;
    if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'hC}) begin
      failures++;
      $display("FAIL rr_flush got valid=%0b req=%0b addr=%h expected 0/1/c",
               inst_valid, mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    tick();
    checks++;
    if ({inst_valid, mem_addr} !== {1'b0, 32'h100}) begin
      failures++;
      $display("FAIL rr_target got valid=%0b addr=%h expected 0/100", inst_valid, mem_addr);
    end
`ifdef PREFETCH_STATS_EN
    checks++;
    if ({stat_fetched, stat_discarded} !== {32'd3, 32'd4}) begin
      failures++;
      $display("FAIL rr_stats got fetched=%0d discarded=%0d expected 3/4", stat_fetched, stat_discarded);
    end
`endif
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h100}) begin
      failures++;
      $display("FAIL rr_word got valid=%0b pc=%h expected 1/100", inst_valid, inst_pc);
    end
  endtask

  // Redirect coinciding with an ack while streaming: the acked word is dropped.
  task automatic test_redirect_ack();
    do_reset();
    mem_ack    = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    checks++;
    if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h200}) begin
      failures++;
      $display("FAIL ra_drop got valid=%0b req=%0b addr=%h expected 0/1/200",
               inst_valid, mem_req, mem_addr);
    end
    tick();
    checks++;
    if ({inst_valid, inst_pc, inst, mem_addr} !== {1'b1, 32'h200, word_of(32'h200), 32'h204}) begin
      failures++;
      $display("FAIL ra_next got valid=%0b pc=%h inst=%h addr=%h expected 1/200/%h/204",
               inst_valid, inst_pc, inst, mem_addr, word_of(32'h200));
    end
    mem_ack    = 1'b0;
    inst_ready = 1'b0;
  endtask

  // Reset pulsed low mid-request: outputs clear immediately, acks ignored.
  task automatic test_reset_mid();
    do_reset();
    mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    tick();
    rst = 1'b0;
    #2;
    checks++;
    if ({mem_req, mem_addr, inst_valid, inst, inst_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL mid_reset_async got req=%0b addr=%h valid=%0b inst=%h pc=%h expected all 0",
               mem_req, mem_addr, inst_valid, inst, inst_pc);
    end
    mem_ack = 1'b1;
    tick();
    checks++;
    if ({mem_req, inst_valid} !== {1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset_ack_ignored got req=%0b valid=%0b expected 0/0", mem_req, inst_valid);
    end
`ifdef PREFETCH_STATS_EN
    checks++;
    if (stat_fetched !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset_stat got %0d expected 0", stat_fetched);
    end
`endif
    rst        = 1'b1;
    inst_ready = 1'b1;
    tick();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL mid_reset_restart got req=%0b addr=%h expected 1/0", mem_req, mem_addr);
    end
    tick();
    checks++;
    if ({inst_valid, inst_pc, mem_addr} !== {1'b1, 32'h0, 32'h4}) begin
      failures++;
      $display("FAIL mid_reset_first got valid=%0b pc=%h addr=%h expected 1/0/4",
               inst_valid, inst_pc, mem_addr);
    end
    mem_ack    = 1'b0;
    inst_ready = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    mem_ack     = 1'b0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_ack_delay();
    test_redirect_discard();
    test_redirect_ready();
    test_redirect_ack();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
